// File: rtl/mem_access_ctrl_if.sv
// Bus bundle for mem_access_ctrl: IF-stage fetch port, MEM-stage load/store port
// and the single memory-side port. The controller connects through "master",
// the surrounding pipeline/memory environment through "slave".
interface mem_access_ctrl_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  // IF stage
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          if_stall;
  // MEM stage
  logic          d_rd;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic          d_stall;
  // memory side
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_ready;
  logic          bus_err;

  modport master (
    input  if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, m_rdata, m_ready,
    output if_rdata, if_done, if_stall, d_rdata, d_done, d_stall,
           m_req, m_we, m_addr, m_wdata, bus_err
  );

  modport slave (
    output if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, m_rdata, m_ready,
    input  if_rdata, if_done, if_stall, d_rdata, d_done, d_stall,
           m_req, m_we, m_addr, m_wdata, bus_err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: arbitrates one single-ported unified memory between instruction
// fetch (read-only) and the MEM stage (load/store). Data access wins over fetch.
// Each access completes with a one-cycle done pulse to its requester; stalls are
// combinational from the request and that pulse.
// Optional feature macro: MEM_ACCESS_CTRL_TIMEOUT_EN -- aborts an access after
// TIMEOUT_CYCLES cycles without m_ready, returns ERR_DATA and sets sticky bus_err.
module mem_access_ctrl #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
  ,
  parameter int unsigned   TIMEOUT_CYCLES = 255,
  parameter logic [DW-1:0] ERR_DATA       = DW'(32'hDEADBEEF)
`endif
) (
  input logic              clk,
  input logic              reset,
  mem_access_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, DACC, IACC, RESP} state_t;

  state_t        state;
  logic          m_req_q;
  logic          m_we_q;
  logic [AW-1:0] m_addr_q;
  logic [DW-1:0] m_wdata_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          if_done_q;
  logic          d_done_q;

`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;
  logic          bus_err_q;
`endif

  // Access sequencer: grant, wait for memory completion, one-cycle response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
      tmo_cnt    <= '0;
      bus_err_q  <= 1'b0;
`endif
    end else begin
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.d_rd || bus.d_wr) begin
            // a combined rd+wr is carried out as a write
            state     <= DACC;
            m_req_q   <= 1'b1;
            m_we_q    <= bus.d_wr;
            m_addr_q  <= bus.d_addr;
            m_wdata_q <= bus.d_wdata;
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
          end else if (bus.if_req) begin
            state    <= IACC;
            m_req_q  <= 1'b1;
            m_we_q   <= 1'b0;
            m_addr_q <= bus.if_addr;
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
          end
        end
        DACC, IACC: begin
          if (bus.m_ready) begin
            m_req_q <= 1'b0;
            state   <= RESP;
            if (state == DACC) begin
              d_done_q <= 1'b1;
              if (!m_we_q) d_rdata_q <= bus.m_rdata;
            end else begin
              if_done_q  <= 1'b1;
              if_rdata_q <= bus.m_rdata;
            end
          end
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
          else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            m_req_q   <= 1'b0;
            bus_err_q <= 1'b1;
            state     <= RESP;
            if (state == DACC) begin
              d_done_q  <= 1'b1;
              d_rdata_q <= ERR_DATA;
            end else begin
              if_done_q  <= 1'b1;
              if_rdata_q <= ERR_DATA;
            end
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
`endif
        end
        // requests are not sampled here; requesters update at the edge leaving RESP
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Registered outputs onto the bus.
  assign bus.m_req    = m_req_q;
  assign bus.m_we     = m_we_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_wdata  = m_wdata_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.if_done  = if_done_q;
  assign bus.d_done   = d_done_q;

  // Pipeline hold signals, released in the done cycle.
  assign bus.if_stall = bus.if_req & ~if_done_q;
  assign bus.d_stall  = (bus.d_rd | bus.d_wr) & ~d_done_q;

`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
  assign bus.bus_err = bus_err_q;
`else
  assign bus.bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed and random access scenarios checked against
// a transaction-level timeline model (grant order, latency, data, stalls).
module tb_mem_access_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [31:0] exp_if_rdata;
  logic [31:0] exp_d_rdata;
  logic [31:0] exp_bus_err;

  mem_access_ctrl_if #(.AW(32), .DW(32)) bus ();

  mem_access_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Check every registered output is at its reset value.
  task automatic check_reset_vals(input string tag);
    check({tag, "_m_req"},    32'(bus.m_req),   32'd0);
    check({tag, "_m_we"},     32'(bus.m_we),    32'd0);
    check({tag, "_m_addr"},   bus.m_addr,       32'd0);
    check({tag, "_m_wdata"},  bus.m_wdata,      32'd0);
    check({tag, "_if_rdata"}, bus.if_rdata,     32'd0);
    check({tag, "_d_rdata"},  bus.d_rdata,      32'd0);
    check({tag, "_if_done"},  32'(bus.if_done), 32'd0);
    check({tag, "_d_done"},   32'(bus.d_done),  32'd0);
    check({tag, "_bus_err"},  32'(bus.bus_err), 32'd0);
  endtask

  // One transaction group issued at a negedge with the controller idle.
  // Timeline model: first grant's m_req high from cycle 1, m_ready dN cycles later,
  // done the cycle after m_ready, one idle cycle, then the second grant.
  task automatic run_txn(input bit do_if, input bit do_rd, input bit do_wr, input bit flush,
                         input logic [31:0] ia, input logic [31:0] da, input logic [31:0] dw,
                         input int d0, input int d1,
                         input logic [31:0] v0, input logic [31:0] v1);
    int          na;
    int          st[2];
    int          en[2];
    int          dn[2];
    bit          isd[2];
    bit          we[2];
    logic [31:0] ad[2];
    logic [31:0] rv[2];
    int          last;
    bit          req_e;
    bit          ifd_e;
    bit          dd_e;
    int          cur;
    na = 0;
    if (do_rd || do_wr) begin
      isd[na] = 1'b1; ad[na] = da; we[na] = do_wr; na++;
    end
    if (do_if) begin
      isd[na] = 1'b0; ad[na] = ia; we[na] = 1'b0; na++;
    end
    if (na == 0) return;
    st[0] = 1; en[0] = st[0] + d0; dn[0] = en[0] + 1; rv[0] = v0;
    st[1] = dn[0] + 2; en[1] = st[1] + d1; dn[1] = en[1] + 1; rv[1] = v1;
    last = dn[na-1] + 1;

    bus.if_req  = do_if;
    bus.if_addr = ia;
    bus.d_rd    = do_rd;
    bus.d_wr    = do_wr;
    bus.d_addr  = da;
    bus.d_wdata = dw;
    bus.m_ready = 1'($urandom);
    bus.m_rdata = $urandom;

    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      req_e = 1'b0; ifd_e = 1'b0; dd_e = 1'b0; cur = 0;
      for (int a = 0; a < na; a++) begin
        if (k >= st[a] && k <= en[a]) begin
          req_e = 1'b1; cur = a;
        end
        if (k == dn[a]) begin
          if (isd[a]) dd_e = 1'b1; else ifd_e = 1'b1;
          if (!we[a]) begin
            if (isd[a]) exp_d_rdata = rv[a]; else exp_if_rdata = rv[a];
          end
        end
      end
      check("m_req",    32'(bus.m_req),    32'(req_e));
      check("if_done",  32'(bus.if_done),  32'(ifd_e));
      check("d_done",   32'(bus.d_done),   32'(dd_e));
      check("if_rdata", bus.if_rdata,      exp_if_rdata);
      check("d_rdata",  bus.d_rdata,       exp_d_rdata);
      check("if_stall", 32'(bus.if_stall), 32'(bus.if_req & ~ifd_e));
      check("d_stall",  32'(bus.d_stall),  32'((bus.d_rd | bus.d_wr) & ~dd_e));
      check("bus_err",  32'(bus.bus_err),  exp_bus_err);
      if (req_e) begin
        check("m_we",   32'(bus.m_we), 32'(we[cur]));
        check("m_addr", bus.m_addr,    ad[cur]);
        if (we[cur]) check("m_wdata", bus.m_wdata, dw);
      end
      // requester side: drop on done, or flush the data request mid-access
      if (dd_e || (flush && k == 1)) begin
        bus.d_rd = 1'b0;
        bus.d_wr = 1'b0;
      end
      if (ifd_e) bus.if_req = 1'b0;
      // memory side: ready at the modelled cycle; random noise while m_req is low
      bus.m_rdata = $urandom;
      if (req_e) begin
        bus.m_ready = (k == en[cur]);
        if (k == en[cur]) bus.m_rdata = rv[cur];
      end else begin
        bus.m_ready = 1'($urandom);
      end
    end
  endtask

  // Reset asserted while an access is outstanding.
  task automatic run_reset_mid();
    bus.d_rd    = 1'b1;
    bus.d_wr    = 1'b0;
    bus.d_addr  = $urandom;
    bus.m_ready = 1'b0;
    @(negedge clk);
    check("rst_pre_m_req", 32'(bus.m_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_reset_vals("rst_mid");
    exp_if_rdata = 32'd0;
    exp_d_rdata  = 32'd0;
    exp_bus_err  = 32'd0;
    bus.d_rd = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("rst_d_stall",  32'(bus.d_stall),  32'd0);
    check("rst_if_stall", 32'(bus.if_stall), 32'd0);
  endtask

`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
  // Load that never sees m_ready: abort after 255 request cycles.
  task automatic run_timeout(input logic [31:0] da);
    bus.d_rd    = 1'b1;
    bus.d_wr    = 1'b0;
    bus.d_addr  = da;
    bus.m_ready = 1'b0;
    for (int k = 1; k <= 257; k++) begin
      @(negedge clk);
      check("to_m_req",  32'(bus.m_req),  32'(k <= 255));
      check("to_d_done", 32'(bus.d_done), 32'(k == 256));
      if (k == 256) begin
        exp_d_rdata = 32'hDEADBEEF;
        exp_bus_err = 32'd1;
      end
      if (k >= 256) begin
        check("to_d_rdata", bus.d_rdata,      exp_d_rdata);
        check("to_bus_err", 32'(bus.bus_err), exp_bus_err);
      end
      if (k == 256) bus.d_rd = 1'b0;
      bus.m_ready = 1'b0;
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    exp_if_rdata = 32'd0;
    exp_d_rdata  = 32'd0;
    exp_bus_err  = 32'd0;
    reset       = 1'b1;
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_rd    = 1'b0;
    bus.d_wr    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.m_rdata = '0;
    bus.m_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("por");
    reset = 1'b0;
    @(negedge clk);

    // fetch with two wait cycles
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 2, 0, 32'h2001000A, 32'h0);
    // simultaneous fetch and store: store first, then fetch
    run_txn(1'b1, 1'b0, 1'b1, 1'b0, 32'h44, 32'h100, 32'h55, 0, 1, $urandom, 32'h13579BDF);
    // load completing in the first request cycle
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h200, 32'h0, 0, 0, 32'hCAFE0001, 32'h0);
    // rd and wr together behave as one write
    run_txn(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h10, 32'hA5A5A5A5, 1, 0, $urandom, 32'h0);

    run_reset_mid();
    run_txn(1'b1, 1'b1, 1'b0, 1'b0, $urandom, $urandom, $urandom, 1, 0, $urandom, $urandom);

    for (int i = 0; i < 40; i++) begin
      bit r_if;
      bit r_rd;
      bit r_wr;
      r_if = 1'($urandom);
      r_rd = 1'($urandom);
      r_wr = 1'($urandom);
      if (!(r_if || r_rd || r_wr)) r_if = 1'b1;
      run_txn(r_if, r_rd, r_wr, ($urandom_range(0, 3) == 0), $urandom, $urandom, $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom, $urandom);
    end

`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
    run_timeout(32'h300);
`else
    // without the timeout feature the request is held as long as needed
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h300, 32'h0, 300, 0, 32'h0BADF00D, 32'h0);
`endif
    run_txn(1'b1, 1'b1, 1'b0, 1'b0, $urandom, $urandom, $urandom, 0, 2, $urandom, $urandom);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
